// File: rtl/maze_tile_arbiter.sv
// Shares a single-port synchronous-read maze tile memory between the video renderer
// (absolute priority) and round-robin game requesters, with a fixed 2-cycle slot pipeline.
module maze_tile_arbiter #(
  parameter int NUM_REQ = 5,
  parameter int MAZE_W  = 20,
  parameter int MAZE_H  = 33,
  parameter int ADDR_W  = 10
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 vid_req,
  input  logic [7:0]           vid_xtile,
  input  logic [7:0]           vid_ytile,
  output logic                 vid_valid,
  output logic [4:0]           vid_data,
  input  logic [NUM_REQ-1:0]   gm_req,
  input  logic [8*NUM_REQ-1:0] gm_xtile,
  input  logic [8*NUM_REQ-1:0] gm_ytile,
  output logic [NUM_REQ-1:0]   gm_ack,
  output logic [4:0]           gm_data,
  output logic                 mem_rd,
  output logic [ADDR_W-1:0]    mem_addr,
  input  logic [4:0]           mem_rdata
);

  localparam int IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

  typedef enum logic [1:0] {G_IDLE, G_WAIT1, G_WAIT2} gstate_t;

  gstate_t            state_q, state_d;
  logic [IDX_W-1:0]   rr_q, rr_d;
  logic               mem_rd_q, mem_rd_d;
  logic [ADDR_W-1:0]  mem_addr_q, mem_addr_d;
  logic               t0_valid_q, t0_valid_d, t0_game_q, t0_game_d, t0_oor_q, t0_oor_d;
  logic [IDX_W-1:0]   t0_idx_q, t0_idx_d;
  logic               t1_valid_q, t1_valid_d, t1_game_q, t1_game_d, t1_oor_q, t1_oor_d;
  logic [IDX_W-1:0]   t1_idx_q, t1_idx_d;
  logic               vid_valid_q, vid_valid_d;
  logic [4:0]         vid_data_q, vid_data_d;
  logic [NUM_REQ-1:0] gm_ack_q, gm_ack_d;
  logic [4:0]         gm_data_q, gm_data_d;

  logic               found;
  logic [IDX_W-1:0]   gnt_idx;
  logic               gm_grant, issue, oor;
  logic [7:0]         slot_x, slot_y;
  logic [15:0]        addr_full;
  logic [4:0]         rdata_eff;

  // First pending requester at or after the round-robin pointer.
  always_comb begin
    int j;
    found   = 1'b0;
    gnt_idx = '0;
    j       = 0;
    for (int k = 0; k < NUM_REQ; k++) begin
      j = int'(rr_q) + k;
      if (j >= NUM_REQ) j = j - NUM_REQ;
      if (!found && gm_req[j]) begin
        found   = 1'b1;
        gnt_idx = IDX_W'(j);
      end
    end
  end

  always_comb begin
    gm_grant  = (state_q == G_IDLE) && !vid_req && found;
    issue     = vid_req || gm_grant;
    slot_x    = vid_req ? vid_xtile : gm_xtile[8*int'(gnt_idx) +: 8];
    slot_y    = vid_req ? vid_ytile : gm_ytile[8*int'(gnt_idx) +: 8];
    addr_full = 16'(slot_y) * 16'(MAZE_W) + 16'(slot_x);
    oor       = (int'(slot_y) >= MAZE_H) || (int'(slot_x) >= MAZE_W);

    mem_rd_d   = issue && !oor;
    mem_addr_d = issue ? addr_full[ADDR_W-1:0] : mem_addr_q;
    t0_valid_d = issue;
    t0_game_d  = !vid_req;
    t0_idx_d   = gnt_idx;
    t0_oor_d   = oor;

    t1_valid_d = t0_valid_q;
    t1_game_d  = t0_game_q;
    t1_idx_d   = t0_idx_q;
    t1_oor_d   = t0_oor_q;

    // Out-of-range slots never read memory, so the stale rdata is masked to blank.
    rdata_eff   = t1_oor_q ? 5'b00000 : mem_rdata;
    vid_valid_d = t1_valid_q && !t1_game_q;
    vid_data_d  = vid_valid_d ? rdata_eff : vid_data_q;
    gm_ack_d    = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      gm_ack_d[i] = t1_valid_q && t1_game_q && (t1_idx_q == IDX_W'(i));
    end
    gm_data_d = (t1_valid_q && t1_game_q) ? rdata_eff : gm_data_q;

    rr_d = rr_q;
    if (gm_grant) begin
      rr_d = (gnt_idx == IDX_W'(NUM_REQ - 1)) ? '0 : IDX_W'(gnt_idx + 1'b1);
    end

    state_d = state_q;
    case (state_q)
      G_IDLE:  if (gm_grant) state_d = G_WAIT1;
      G_WAIT1: state_d = G_WAIT2;
      G_WAIT2: state_d = G_IDLE;
      default: state_d = G_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= G_IDLE;
      rr_q        <= '0;
      mem_rd_q    <= 1'b0;
      mem_addr_q  <= '0;
      t0_valid_q  <= 1'b0;
      t0_game_q   <= 1'b0;
      t0_idx_q    <= '0;
      t0_oor_q    <= 1'b0;
      t1_valid_q  <= 1'b0;
      t1_game_q   <= 1'b0;
      t1_idx_q    <= '0;
      t1_oor_q    <= 1'b0;
      vid_valid_q <= 1'b0;
      vid_data_q  <= '0;
      gm_ack_q    <= '0;
      gm_data_q   <= '0;
    end else begin
      state_q     <= state_d;
      rr_q        <= rr_d;
      mem_rd_q    <= mem_rd_d;
      mem_addr_q  <= mem_addr_d;
      t0_valid_q  <= t0_valid_d;
      t0_game_q   <= t0_game_d;
      t0_idx_q    <= t0_idx_d;
      t0_oor_q    <= t0_oor_d;
      t1_valid_q  <= t1_valid_d;
      t1_game_q   <= t1_game_d;
      t1_idx_q    <= t1_idx_d;
      t1_oor_q    <= t1_oor_d;
      vid_valid_q <= vid_valid_d;
      vid_data_q  <= vid_data_d;
      gm_ack_q    <= gm_ack_d;
      gm_data_q   <= gm_data_d;
    end
  end

  assign vid_valid = vid_valid_q;
  assign vid_data  = vid_data_q;
  assign gm_ack    = gm_ack_q;
  assign gm_data   = gm_data_q;
  assign mem_rd    = mem_rd_q;
  assign mem_addr  = mem_addr_q;

endmodule

// File: tb/tb_maze_tile_arbiter.sv
// Directed bench for maze_tile_arbiter: a behavioural tile memory answers reads one
// cycle later; every expected value below is hand-derived from tile coordinates.
module tb_maze_tile_arbiter;

  logic        clk = 1'b0;
  logic        rst;
  logic        vid_req;
  logic [7:0]  vid_xtile, vid_ytile;
  logic        vid_valid;
  logic [4:0]  vid_data;
  logic [4:0]  gm_req;
  logic [39:0] gm_xtile, gm_ytile;
  logic [4:0]  gm_ack;
  logic [4:0]  gm_data;
  logic        mem_rd;
  logic [9:0]  mem_addr;
  logic [4:0]  mem_rdata;

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  maze_tile_arbiter dut (
    .clk(clk), .rst(rst),
    .vid_req(vid_req), .vid_xtile(vid_xtile), .vid_ytile(vid_ytile),
    .vid_valid(vid_valid), .vid_data(vid_data),
    .gm_req(gm_req), .gm_xtile(gm_xtile), .gm_ytile(gm_ytile),
    .gm_ack(gm_ack), .gm_data(gm_data),
    .mem_rd(mem_rd), .mem_addr(mem_addr), .mem_rdata(mem_rdata)
  );

  // Tile contents are a fixed never-zero pattern of the address.
  function automatic logic [4:0] tile(input int a);
    return 5'(((a * 7 + 3) % 31) + 1);
  endfunction

  always @(posedge clk) begin
    if (mem_rd) mem_rdata <= tile(int'(mem_addr));
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic set_gm(input int i, input logic [7:0] x, input logic [7:0] y);
    gm_xtile[8*i +: 8] = x;
    gm_ytile[8*i +: 8] = y;
  endtask

  initial begin
    int order [4];
    int addr_of [5];
    rst = 1'b1; vid_req = 1'b0; vid_xtile = '0; vid_ytile = '0;
    gm_req = '0; gm_xtile = '0; gm_ytile = '0; mem_rdata = 5'd0;
    step(); step();
    rst = 1'b0;
    check("rst_vid_valid", 32'(vid_valid), 0);
    check("rst_gm_ack",    32'(gm_ack), 0);
    check("rst_mem_rd",    32'(mem_rd), 0);
    check("rst_mem_addr",  32'(mem_addr), 0);

    // 1: video lookup at (3,2) -> address 43
    vid_req = 1'b1; vid_xtile = 8'd3; vid_ytile = 8'd2;
    step();
    vid_req = 1'b0;
    check("t1_mem_rd",   32'(mem_rd), 1);
    check("t1_mem_addr", 32'(mem_addr), 43);
    check("t1_valid_e0", 32'(vid_valid), 0);
    step();
    check("t1_valid_e1", 32'(vid_valid), 0);
    step();
    check("t1_valid_e2", 32'(vid_valid), 1);
    check("t1_data",     32'(vid_data), 32'(tile(43)));

    // 2: two out-of-range video lookups back to back
    vid_req = 1'b1; vid_xtile = 8'd19; vid_ytile = 8'd33;
    step();
    check("t2_mem_rd_a", 32'(mem_rd), 0);
    vid_xtile = 8'd20; vid_ytile = 8'd0;
    step();
    check("t2_mem_rd_b", 32'(mem_rd), 0);
    vid_req = 1'b0;
    step();
    check("t2_valid_a", 32'(vid_valid), 1);
    check("t2_data_a",  32'(vid_data), 0);
    step();
    check("t2_valid_b", 32'(vid_valid), 1);
    check("t2_data_b",  32'(vid_data), 0);
    step();
    check("t2_valid_off", 32'(vid_valid), 0);

    // 3: round robin over requesters 0,2,4
    set_gm(0, 8'd1, 8'd1);   addr_of[0] = 21;
    set_gm(1, 8'd2, 8'd3);   addr_of[1] = 62;
    set_gm(2, 8'd5, 8'd10);  addr_of[2] = 205;
    set_gm(3, 8'd7, 8'd7);   addr_of[3] = 147;
    set_gm(4, 8'd19, 8'd32); addr_of[4] = 659;
    order = '{0, 2, 4, 0};
    gm_req = 5'b10101;
    for (int t = 0; t < 4; t++) begin
      step();
      check($sformatf("t3_gap1_%0d", t), 32'(gm_ack), 0);
      step();
      check($sformatf("t3_gap2_%0d", t), 32'(gm_ack), 0);
      step();
      check($sformatf("t3_ack_%0d", t),  32'(gm_ack), 32'(5'b1 << order[t]));
      check($sformatf("t3_data_%0d", t), 32'(gm_data), 32'(tile(addr_of[order[t]])));
    end
    gm_req = '0;
    step();

    // 4: video starves requester 1 for 10 cycles
    gm_req = 5'b00010;
    vid_req = 1'b1; vid_xtile = 8'd0; vid_ytile = 8'd0;
    for (int t = 0; t < 10; t++) begin
      step();
      check($sformatf("t4_starve_%0d", t), 32'(gm_ack), 0);
    end
    vid_req = 1'b0;
    step();
    check("t4_grant_edge", 32'(gm_ack), 0);
    step();
    check("t4_wait", 32'(gm_ack), 0);
    step();
    check("t4_ack",  32'(gm_ack), 32'(5'b00010));
    check("t4_data", 32'(gm_data), 32'(tile(62)));
    gm_req = '0;

    // 5: game grant to requester 3, then two video slots
    gm_req = 5'b01000;
    step();
    vid_req = 1'b1; vid_xtile = 8'd3; vid_ytile = 8'd2;
    step();
    check("t5_ack_e1", 32'(gm_ack), 0);
    vid_xtile = 8'd5; vid_ytile = 8'd10;
    step();
    check("t5_ack",      32'(gm_ack), 32'(5'b01000));
    check("t5_gm_data",  32'(gm_data), 32'(tile(147)));
    check("t5_vv_e2",    32'(vid_valid), 0);
    gm_req = '0; vid_req = 1'b0;
    step();
    check("t5_vv_a",   32'(vid_valid), 1);
    check("t5_vd_a",   32'(vid_data), 32'(tile(43)));
    check("t5_ack_a",  32'(gm_ack), 0);
    step();
    check("t5_vv_b",   32'(vid_valid), 1);
    check("t5_vd_b",   32'(vid_data), 32'(tile(205)));
    check("t5_ack_b",  32'(gm_ack), 0);
    check("t5_gd_hold", 32'(gm_data), 32'(tile(147)));
    step();
    check("t5_vv_off", 32'(vid_valid), 0);

    // 6: reset one cycle after a grant aborts the transaction
    gm_req = 5'b00001;
    step();
    rst = 1'b1;
    step();
    rst = 1'b0; gm_req = '0;
    check("t6_vid_valid", 32'(vid_valid), 0);
    check("t6_vid_data",  32'(vid_data), 0);
    check("t6_gm_data",   32'(gm_data), 0);
    check("t6_mem_rd",    32'(mem_rd), 0);
    check("t6_mem_addr",  32'(mem_addr), 0);
    for (int t = 0; t < 4; t++) begin
      step();
      check($sformatf("t6_no_ack_%0d", t), 32'(gm_ack), 0);
    end
    gm_req = 5'b00101;
    step();
    step();
    check("t6_fresh_wait", 32'(gm_ack), 0);
    step();
    check("t6_fresh_ack",  32'(gm_ack), 32'(5'b00001));
    check("t6_fresh_data", 32'(gm_data), 32'(tile(21)));
    gm_req = '0;
    step();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
